bitslam_reg_writer: RTL and testbench

Host-side bus master for the `yupferris_bitslam` sound block's register-write bus. It accepts register writes (3-bit register address, 6-bit value) on a valid/ready port and buffers them in a small FIFO. It then serialises each write into the chip's two-phase `addr_data_sel` / `addr_data` protocol, skipping the address phase when the chip already holds the target address. It sits between a sequencer/CPU and the sound block; its bus outputs drive `io_in[1]` and `io_in[7:2]` directly.

---
 rtl/bitslam_reg_writer.sv | 123 ++++++++++++
 tb/tb_bitslam_reg_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bitslam_reg_writer.sv
// Bus master for the bitslam sound block: FIFO-buffered register writes serialised
// into the two-phase addr_data_sel / addr_data protocol with address-phase caching.
module bitslam_reg_writer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [2:0]                    wr_addr,
   input  logic [5:0]                    wr_data,
   output logic                          bus_sel,
   output logic [5:0]                    bus_addr_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t      state_q;
   logic [2:0]  curAddr_q;
   logic        cacheValid_q;
   logic        busSel_q;
   logic [5:0]  busAddrData_q;

   logic [8:0]  fifoMem_q [FIFO_DEPTH];
   logic [AW:0] wrPtr_q;
   logic [AW:0] rdPtr_q;
   logic [AW:0] wrPtr_d;
   logic [AW:0] rdPtr_d;

   logic        fifoFull;
   logic        fifoEmpty;
   logic        push;
   logic        pop;
   logic [2:0]  headAddr;
   logic [5:0]  headData;

   // The extra pointer MSB tells a full FIFO apart from an empty one.
   assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign push      = wr_valid && !fifoFull;
   assign pop       = (state_q == DATA);
   assign wrPtr_d   = push ? wrPtr_q + 1'b1 : wrPtr_q;
   assign rdPtr_d   = pop ? rdPtr_q + 1'b1 : rdPtr_q;
   assign headAddr  = fifoMem_q[rdPtr_q[AW-1:0]][8:6];
   assign headData  = fifoMem_q[rdPtr_q[AW-1:0]][5:0];

   assign wr_ready      = !fifoFull;
   assign busy          = !fifoEmpty || (state_q != IDLE);
   assign fifo_level    = wrPtr_q - rdPtr_q;
   assign bus_sel       = busSel_q;
   assign bus_addr_data = busAddrData_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q[AW-1:0]] <= {wr_addr, wr_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Bus outputs are registered alongside the state so they follow the next state;
   // the head entry is stable until the pop at the end of DATA.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         curAddr_q     <= 3'd0;
         cacheValid_q  <= 1'b0;
         busSel_q      <= 1'b0;
         busAddrData_q <= 6'h00;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifoEmpty && cacheValid_q && (headAddr == curAddr_q)) begin
                  state_q       <= DATA;
                  busSel_q      <= 1'b1;
                  busAddrData_q <= headData;
               end else if (!fifoEmpty) begin
                  state_q       <= ADDR;
                  busSel_q      <= 1'b0;
                  busAddrData_q <= {3'b000, headAddr};
               end else begin
                  busSel_q      <= 1'b0;
                  busAddrData_q <= {3'b000, curAddr_q};
               end
            end
            ADDR: begin
               curAddr_q     <= headAddr;
               cacheValid_q  <= 1'b1;
               state_q       <= DATA;
               busSel_q      <= 1'b1;
               busAddrData_q <= headData;
            end
            DATA: begin
               state_q       <= IDLE;
               busSel_q      <= 1'b0;
               busAddrData_q <= {3'b000, curAddr_q};
            end
            default: begin
               state_q       <= IDLE;
               busSel_q      <= 1'b0;
               busAddrData_q <= {3'b000, curAddr_q};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitslam_reg_writer.sv
// Directed bench for bitslam_reg_writer with a small register-file model of the sound chip.
module tb_bitslam_reg_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [2:0] wr_addr = 3'd0;
   logic [5:0] wr_data = 6'd0;
   logic       bus_sel;
   logic [5:0] bus_addr_data;
   logic       busy;
   logic [2:0] fifo_level;

   int checkCount = 0;
   int errorCount = 0;

   logic [2:0] chipAddr = 3'd0;
   logic [5:0] chipRegs [8];
   logic [5:0] dataLog [$];
   int         stallCount = 0;
   int         fullCycles = 0;
   int         cycleCount = 0;

   bitslam_reg_writer #(.FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .bus_sel       (bus_sel),
      .bus_addr_data (bus_addr_data),
      .busy          (busy),
      .fifo_level    (fifo_level)
   );

   always #5 clk = ~clk;

   // Chip model: latches the address when bus_sel is low, writes the register when high.
   always @(posedge clk) begin
      cycleCount = cycleCount + 1;
      if (wr_valid && !wr_ready) stallCount = stallCount + 1;
      if (fifo_level == 3'd4) fullCycles = fullCycles + 1;
      if (bus_sel) begin
         chipRegs[chipAddr] = bus_addr_data;
         dataLog.push_back(bus_addr_data);
      end else begin
         chipAddr = bus_addr_data[2:0];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount = checkCount + 1;
      if (observed !== expected) begin
         errorCount = errorCount + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [5:0] d);
      wr_valid = v;
      wr_addr  = a;
      wr_data  = d;
   endtask

   task automatic expectBus(input string tag, input logic s, input logic [5:0] ad);
      checkOutput({tag, "_sel"}, 32'(bus_sel), 32'(s));
      checkOutput({tag, "_ad"}, 32'(bus_addr_data), 32'(ad));
   endtask

   // Holds the request until the handshake completes; returns at the negedge after acceptance.
   task automatic pushWrite(input logic [2:0] a, input logic [5:0] d);
      logic accepted;
      int   n;
      applyStimulus(1'b1, a, d);
      accepted = wr_ready;
      n = 0;
      @(negedge clk);
      while (!accepted && n < 50) begin
         accepted = wr_ready;
         n = n + 1;
         @(negedge clk);
      end
      checkOutput("push_accept", 32'(accepted), 32'd1);
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n = n + 1;
      end
      checkOutput("drain_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int          startIdx;
      int          startCycle;
      logic [5:0]  expData [6];

      for (int i = 0; i < 8; i++) chipRegs[i] = 6'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Asynchronous reset while idle
      #2 rst = 1'b1;
      #1;
      expectBus("rst_idle", 1'b0, 6'h00);
      checkOutput("rst_ready", 32'(wr_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_level", 32'(fifo_level), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single write after reset
      applyStimulus(1'b1, 3'd2, 6'h15);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 6'h00);
      expectBus("w1_idle", 1'b0, 6'h00);
      checkOutput("w1_level", 32'(fifo_level), 32'd1);
      checkOutput("w1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      expectBus("w1_addr", 1'b0, 6'h02);
      @(negedge clk);
      expectBus("w1_data", 1'b1, 6'h15);
      @(negedge clk);
      expectBus("w1_post", 1'b0, 6'h02);
      checkOutput("w1_busy_done", 32'(busy), 32'd0);

      // Same-address pair: second write skips the address phase
      applyStimulus(1'b1, 3'd1, 6'h3F);
      @(negedge clk);
      applyStimulus(1'b1, 3'd1, 6'h01);
      expectBus("pair_idle0", 1'b0, 6'h02);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 6'h00);
      expectBus("pair_addr", 1'b0, 6'h01);
      @(negedge clk);
      expectBus("pair_data0", 1'b1, 6'h3F);
      @(negedge clk);
      expectBus("pair_idle1", 1'b0, 6'h01);
      @(negedge clk);
      expectBus("pair_data1", 1'b1, 6'h01);
      @(negedge clk);
      expectBus("pair_post", 1'b0, 6'h01);
      checkOutput("pair_busy", 32'(busy), 32'd0);

      // Backpressure: alternating addresses drain at 3 cycles/write, so the FIFO fills
      expData = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
      startIdx = dataLog.size();
      for (int i = 0; i < 6; i++) pushWrite((i % 2 == 0) ? 3'd3 : 3'd4, expData[i]);
      applyStimulus(1'b0, 3'd0, 6'h00);
      waitIdle(100);
      checkOutput("bp_stalls", 32'(stallCount), 32'd2);
      checkOutput("bp_full_cycles", 32'(fullCycles), 32'd4);
      checkOutput("bp_count", 32'(dataLog.size() - startIdx), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (startIdx + i < dataLog.size())
            checkOutput($sformatf("bp_order%0d", i), 32'(dataLog[startIdx + i]), 32'(expData[i]));
      end

      // Reset during the address phase
      applyStimulus(1'b1, 3'd5, 6'h11);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 6'h00);
      @(negedge clk);
      expectBus("ra_addr", 1'b0, 6'h05);
      #2 rst = 1'b1;
      #1;
      expectBus("ra_reset", 1'b0, 6'h00);
      checkOutput("ra_level", 32'(fifo_level), 32'd0);
      checkOutput("ra_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      startIdx = dataLog.size();
      applyStimulus(1'b1, 3'd5, 6'h2A);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 6'h00);
      expectBus("ra_idle", 1'b0, 6'h00);
      @(negedge clk);
      expectBus("ra_readdr", 1'b0, 6'h05);
      @(negedge clk);
      expectBus("ra_data", 1'b1, 6'h2A);
      @(negedge clk);
      checkOutput("ra_logged", 32'(dataLog.size() - startIdx), 32'd1);

      // End-to-end into the chip model
      startCycle = cycleCount;
      pushWrite(3'd0, 6'h05);
      pushWrite(3'd1, 6'h0F);
      pushWrite(3'd2, 6'h08);
      pushWrite(3'd3, 6'h09);
      pushWrite(3'd4, 6'h3F);
      applyStimulus(1'b0, 3'd0, 6'h00);
      waitIdle(100);
      checkOutput("e2e_cycles", 32'(cycleCount - startCycle), 32'd16);
      checkOutput("e2e_v0_div", 32'(chipRegs[0]), 32'h05);
      checkOutput("e2e_v0_tap", 32'(chipRegs[1]), 32'h0F);
      checkOutput("e2e_v1_div", 32'(chipRegs[2]), 32'h08);
      checkOutput("e2e_v1_tap", 32'(chipRegs[3]), 32'h09);
      checkOutput("e2e_mixer", 32'(chipRegs[4]), 32'h3F);
      checkOutput("e2e_final_bus", 32'(bus_addr_data), 32'h04);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
